// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and helpers for the PmodKYPD scan controller: FSM states,
// the 5-bit key candidate encoding and the column/row to key-code map.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL
    } scan_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } cand_t;

    localparam cand_t NO_KEY = '{valid: 1'b0, code: 4'h0};

    // Key legend of the PmodKYPD, indexed by driven column and sensed row.
    function automatic logic [3:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        case ({col, row})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h4;
            4'b00_10: code = 4'h7;
            4'b00_11: code = 4'h0;
            4'b01_00: code = 4'h2;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h8;
            4'b01_11: code = 4'hF;
            4'b10_00: code = 4'h3;
            4'b10_01: code = 4'h6;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'hB;
            4'b11_10: code = 4'hC;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Valid/ready key event channel from the keypad scanner to its consumer.
interface keypad_scan_ctrl_if;

    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        output key_ready
    );

endinterface

// File: rtl/keypad_scan_ctrl_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad row lines.
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n_i,
    output logic [3:0] row_n_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= row_n_i;
            sync_q <= meta_q;
        end
    end

    assign row_n_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Sequenced 4x4 keypad scanner with whole-scan debounce and a single-entry
// valid/ready key event output. Define KEYPAD_REPEAT_EN to enable auto-repeat.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int REPEAT_CYCLES  = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [3:0]         col_n,
    input  logic [3:0]         row_n,
    keypad_scan_ctrl_if.master key_if
);

    if (SETTLE_CYCLES < 3 || DEBOUNCE_SCANS < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("keypad_scan_ctrl: parameter below its minimum");
    end

    localparam int              SW         = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0]   SETTLE_END = SW'(SETTLE_CYCLES - 2);
    localparam int              DW         = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0]   DB_MAX     = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0]   DB_ONE     = DW'(1);

    scan_state_e   state_q;
    logic [1:0]    col_idx_q;
    logic [SW-1:0] settle_cnt_q;
    cand_t         scan_q;
    cand_t         cand_q;
    logic [DW-1:0] stable_cnt_q;
    logic [3:0]    col_n_q;
    logic [3:0]    code_q;
    logic          valid_q;
    logic          held_q;

    logic [3:0]    row_sync_n;
    logic [3:0]    row_hit;
    logic [1:0]    first_row;
    logic          eval_same;
    logic [DW-1:0] stable_d;
    logic          press_ok;
    logic          release_ok;
    logic          swap;

    keypad_row_sync u_row_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .row_n_i (row_n),
        .row_n_o (row_sync_n)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        row_hit   = ~row_sync_n;
        first_row = 2'd3;
        if (row_hit[0])      first_row = 2'd0;
        else if (row_hit[1]) first_row = 2'd1;
        else if (row_hit[2]) first_row = 2'd2;

        eval_same = (scan_q == cand_q);
        if (!eval_same)                stable_d = DB_ONE;
        else if (stable_cnt_q == DB_MAX) stable_d = DB_MAX;
        else                           stable_d = stable_cnt_q + DB_ONE;

        press_ok   = scan_q.valid && (stable_d == DB_MAX) && !held_q;
        release_ok = !scan_q.valid && (stable_d == DB_MAX);
        // A jump straight to another key counts as a release of the old one.
        swap       = scan_q.valid && cand_q.valid && !eval_same;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int            RW       = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]            rpt_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_idx_q    <= 2'd0;
            settle_cnt_q <= '0;
            scan_q       <= NO_KEY;
            cand_q       <= NO_KEY;
            stable_cnt_q <= '0;
            col_n_q      <= 4'b1111;
            code_q       <= 4'h0;
            valid_q      <= 1'b0;
            held_q       <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q    <= '0;
`endif
        end else begin
            if (valid_q && key_if.key_ready) valid_q <= 1'b0;

`ifdef KEYPAD_REPEAT_EN
            if (!held_q || (state_q == ST_EVAL && !eval_same)) begin
                rpt_cnt_q <= '0;
            end else if (rpt_cnt_q == RPT_LAST) begin
                rpt_cnt_q <= '0;
                if (!valid_q) begin
                    code_q  <= cand_q.code;
                    valid_q <= 1'b1;
                end
            end else begin
                rpt_cnt_q <= rpt_cnt_q + 1'b1;
            end
`endif

            case (state_q)
                ST_IDLE: begin
                    col_idx_q <= 2'd0;
                    col_n_q   <= col_drive(2'd0);
                    scan_q    <= NO_KEY;
                    state_q   <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    settle_cnt_q <= '0;
                    state_q      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt_q <= settle_cnt_q + 1'b1;
                    if (settle_cnt_q == SETTLE_END) state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (!scan_q.valid && (|row_hit)) begin
                        scan_q <= '{valid: 1'b1, code: key_lookup(col_idx_q, first_row)};
                    end
                    if (col_idx_q == 2'd3) begin
                        col_n_q <= 4'b1111;
                        state_q <= ST_EVAL;
                    end else begin
                        col_idx_q <= col_idx_q + 2'd1;
                        col_n_q   <= col_drive(col_idx_q + 2'd1);
                        state_q   <= ST_DRIVE;
                    end
                end
                ST_EVAL: begin
                    cand_q       <= scan_q;
                    stable_cnt_q <= stable_d;
                    if (press_ok) begin
                        held_q <= 1'b1;
                        if (!valid_q) begin
                            code_q  <= scan_q.code;
                            valid_q <= 1'b1;
                        end
                    end
                    if (release_ok || swap) held_q <= 1'b0;
                    scan_q    <= NO_KEY;
                    col_idx_q <= 2'd0;
                    col_n_q   <= col_drive(2'd0);
                    state_q   <= ST_DRIVE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign col_n            = col_n_q;
    assign key_if.key_code  = code_q;
    assign key_if.key_valid = valid_q;
    assign key_if.key_held  = held_q;

endmodule
